ulpi_link_ctrl: RTL and testbench
=================================

// Module: ulpi_link_ctrl
// PURPOSE
//  Link-side ULPI controller; sits between USB packet logic and the ULPI PHY pins.
//  Tx: frames AXI-S USB packets as TX CMD, data bytes and STP. Rx: turns PHY-driven
//  bursts into AXI-S packets with a correct tlast, and captures RX CMD line status.
//  Bench DUT partner of the PHY model; both ends speak ULPI.
// PARAMETERS
//  MAX_PKT_LEN  1027   Rx bytes allowed per packet; beyond this the packet is babble.
//  ABORT_BYTE   8'hFF  Data driven with STP when a Tx packet underruns.
// PORTS
//  clock         in   1  system clock (ULPI 60 MHz domain)
//  reset         in   1  synchronous, active-high
//  ulpi_dir_i    in   1  PHY owns bus when 1
//  ulpi_nxt_i    in   1  PHY throttle / Rx-data qualifier
//  ulpi_stp_o    out  1  link stop strobe
//  ulpi_data_io  io   8  bus; driven by link only when dir_i=0
//  s_tvalid      in   1  Tx stream valid; first byte of packet is the PID
//  s_tready      out  1  Tx byte accepted by PHY this cycle
//  s_tlast       in   1  Tx last byte
//  s_tdata       in   8  Tx byte
//  m_tvalid      out  1  Rx stream valid
//  m_tready      in   1  Rx consumer ready (PHY cannot be stalled)
//  m_tlast       out  1  Rx last byte of packet
//  m_tdata       out  8  Rx byte
//  linestate_o   out  2  RX CMD bits [1:0], last captured
//  rxevent_o     out  2  RX CMD bits [5:4], last captured
//  err_o         out  3  sticky {babble, rx_overflow, tx_underrun}; cleared by reset only
// BEHAVIOUR
//  Reset: state IDLE; stp_o=0, bus released, s_tready=0, m_tvalid=0, m_tlast=0,
//   linestate_o=2'b00, rxevent_o=2'b00, err_o=0, hold register empty, length counter 0.
//  Outputs are registered, except s_tready and ulpi_data_io (combinational on state,
//   nxt and dir).
//  States: IDLE, TXCMD, TXDATA, STOP, RXTURN, RECV.
//  IDLE: bus driven 8'h00.
//   - dir_i=1 -> RXTURN. This has priority over a pending s_tvalid.
//   - otherwise s_tvalid -> TXCMD.
//  TXCMD: drive {4'b0100, s_tdata[3:0]}.
//   - nxt_i=1 & dir_i=0 -> s_tready=1 (PID consumed); go to STOP if s_tlast, else TXDATA.
//   - dir_i=1 (PHY preempts) -> RXTURN; PID not consumed; Tx retried from TXCMD later.
//  TXDATA: drive s_tdata; s_tready = nxt_i & !dir_i & s_tvalid.
//   - accepted byte with s_tlast -> STOP.
//   - nxt_i=1 & !s_tvalid -> underrun: set err[0], STOP with data=ABORT_BYTE.
//   - dir_i=1 mid-packet -> abort Tx, go RXTURN; remaining bytes stay in the stream,
//     and the upstream block flushes them.
//  STOP: one cycle, stp_o=1, data=8'h00 (or ABORT_BYTE on underrun); next IDLE.
//   - stp_o is never asserted while dir_i=1.
//  RXTURN: one turnaround cycle; data ignored, bus released; next RECV.
//   - dir_i=0 here -> IDLE.
//  RECV, sampled each cycle:
//   - dir_i=1 & nxt_i=0: RX CMD; update linestate_o/rxevent_o; no stream byte.
//   - dir_i=1 & nxt_i=1: packet byte. If the hold register is full, push the held byte
//     to m_* with tlast=0; then load the new byte.
//   - dir_i=0: end of burst; push the held byte (if any) with m_tlast=1; -> IDLE.
//     dir falling with nothing held emits nothing.
//  Rx output register: a push while m_tvalid=1 & m_tready=0 drops the byte and sets
//   err[1]; the packet is then discarded up to its end, though tlast is still emitted
//   if its slot is free.
//  Length counter: 11 bits, cleared on entry to RXTURN. Byte number MAX_PKT_LEN+1 sets
//   err[2]; further bytes are dropped; tlast is still generated at dir fall.
//  Reset mid-operation: immediate return to reset values; bus released same cycle;
//   a partial Rx packet is discarded with no tlast.
// TESTING
//  T1 Tx ACK: s_tdata=8'hD2, s_tlast=1, nxt high 1 cycle -> bus 8'h42, s_tready 1 cycle,
//     stp_o=1 next cycle with data 8'h00.
//  T2 Tx DATA0 {C3,01,02,03} with nxt low 2 cycles mid-packet -> bus 43,01,02,03;
//     s_tready only on nxt cycles; single stp after 03.
//  T3 Rx: dir 1, RXCMD 8'h01, nxt bytes {4B,AA,BB}, dir 0 -> m_* gives 4B,AA,BB with
//     tlast on BB; linestate_o=2'b01.
//  T4 Preempt: dir_i rises in TXCMD -> no s_tready, no stp, Rx burst received,
//     then Tx retried and completes.
//  T5 Underrun: s_tvalid drops in TXDATA while nxt=1 -> stp_o with 8'hFF; err_o=3'b001.
//  T6 m_tready held 0 during a 3-byte Rx -> err_o[1]=1, no corrupted tlast;
//     next packet received clean.

Source files
------------

// File: rtl/ulpi_link_ctrl.sv
// Link-side ULPI controller: frames AXI-S Tx packets as TX CMD/data/STP and turns PHY bursts into AXI-S Rx packets.
// Latency: Tx byte is on the bus in the cycle s_tready is high; an Rx byte waits in a one-byte hold until the next byte or dir fall, so tlast can be attached.
// Backpressure: Tx is paced by ulpi_nxt_i through s_tready. Rx cannot stall the PHY, so a push into a full output register drops the byte and flags rx_overflow.
//
// Ports: clock/reset (sync, active-high); ulpi_dir_i, ulpi_nxt_i, ulpi_stp_o, ulpi_data_io (PHY pins);
//        s_t* Tx stream in (first byte is the PID); m_t* Rx stream out;
//        linestate_o/rxevent_o last RX CMD fields; err_o sticky {babble, rx_overflow, tx_underrun}.
module ulpi_link_ctrl #(
    parameter int         MAX_PKT_LEN = 1027,
    parameter logic [7:0] ABORT_BYTE  = 8'hFF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ulpi_dir_i,
    input  logic       ulpi_nxt_i,
    output logic       ulpi_stp_o,
    inout  wire  [7:0] ulpi_data_io,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  logic       s_tlast,
    input  logic [7:0] s_tdata,
    output logic       m_tvalid,
    input  logic       m_tready,
    output logic       m_tlast,
    output logic [7:0] m_tdata,
    output logic [1:0] linestate_o,
    output logic [1:0] rxevent_o,
    output logic [2:0] err_o
);
    localparam logic [10:0] MAX_LEN = 11'(MAX_PKT_LEN);

    typedef enum logic [2:0] {IDLE, TXCMD, TXDATA, STOP, RXTURN, RECV} state_t;

    state_t      state;
    state_t      next_state;

    logic        abort_q;      // STOP cycle ends an underrun packet
    logic        hold_vld;
    logic [7:0]  hold_dat;
    logic [10:0] len_cnt;
    logic        rx_discard;   // rest of this Rx packet is thrown away after an overflow

    logic        drv_en;
    logic [7:0]  drv_dat;
    logic        tx_underrun;
    logic        rx_cmd;
    logic        rx_byte;
    logic        rx_keep;
    logic        rx_end;
    logic        push_vld;
    logic        push_blocked;

    // Link drives only while it owns the bus; reset releases it immediately.
    assign ulpi_data_io = drv_en ? drv_dat : 8'bz;

    always_comb begin
        next_state  = state;
        s_tready    = 1'b0;
        drv_en      = !reset && !ulpi_dir_i;
        drv_dat     = 8'h00;
        tx_underrun = 1'b0;
        case (state)
            IDLE: begin
                // PHY turnaround wins over a pending Tx packet
                if (ulpi_dir_i)    next_state = RXTURN;
                else if (s_tvalid) next_state = TXCMD;
            end
            TXCMD: begin
                drv_dat = {4'b0100, s_tdata[3:0]};
                if (ulpi_dir_i) begin
                    // preempted: PID stays in the stream and is retried later
                    next_state = RXTURN;
                end else if (ulpi_nxt_i) begin
                    s_tready   = 1'b1;
                    next_state = s_tlast ? STOP : TXDATA;
                end
            end
            TXDATA: begin
                drv_dat = s_tdata;
                if (ulpi_dir_i) begin
                    next_state = RXTURN;
                end else if (ulpi_nxt_i) begin
                    if (s_tvalid) begin
                        s_tready = 1'b1;
                        if (s_tlast) next_state = STOP;
                    end else begin
                        tx_underrun = 1'b1;
                        next_state  = STOP;
                    end
                end
            end
            STOP: begin
                drv_dat    = abort_q ? ABORT_BYTE : 8'h00;
                next_state = IDLE;
            end
            RXTURN: begin
                drv_en     = 1'b0;
                next_state = ulpi_dir_i ? RECV : IDLE;
            end
            RECV: begin
                drv_en = 1'b0;
                if (!ulpi_dir_i) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (reset) s_tready = 1'b0;
    end

    always_comb begin
        rx_cmd       = (state == RECV) && ulpi_dir_i && !ulpi_nxt_i;
        rx_byte      = (state == RECV) && ulpi_dir_i && ulpi_nxt_i;
        rx_keep      = rx_byte && (len_cnt < MAX_LEN);
        rx_end       = (state == RECV) && !ulpi_dir_i;
        push_vld     = hold_vld && (rx_keep || rx_end);
        push_blocked = m_tvalid && !m_tready;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            ulpi_stp_o  <= 1'b0;
            abort_q     <= 1'b0;
            hold_vld    <= 1'b0;
            hold_dat    <= 8'h00;
            len_cnt     <= 11'd0;
            rx_discard  <= 1'b0;
            m_tvalid    <= 1'b0;
            m_tlast     <= 1'b0;
            m_tdata     <= 8'h00;
            linestate_o <= 2'b00;
            rxevent_o   <= 2'b00;
            err_o       <= 3'b000;
        end else begin
            state      <= next_state;
            ulpi_stp_o <= (next_state == STOP);
            abort_q    <= tx_underrun;
            if (tx_underrun) err_o[0] <= 1'b1;

            if (m_tvalid && m_tready) begin
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
            end

            // next_state is RXTURN only on entry, never while already there
            if (next_state == RXTURN) begin
                len_cnt    <= 11'd0;
                hold_vld   <= 1'b0;
                rx_discard <= 1'b0;
            end

            if (rx_cmd) begin
                linestate_o <= ulpi_data_io[1:0];
                rxevent_o   <= ulpi_data_io[5:4];
            end

            // counter saturates one past the limit so babble is flagged once
            if (rx_byte && (len_cnt <= MAX_LEN)) len_cnt <= len_cnt + 11'd1;
            if (rx_byte && (len_cnt == MAX_LEN)) err_o[2] <= 1'b1;

            if (rx_keep) begin
                hold_vld <= 1'b1;
                hold_dat <= ulpi_data_io;
            end
            if (rx_end) hold_vld <= 1'b0;

            if (push_vld) begin
                if (push_blocked) begin
                    err_o[1]   <= 1'b1;
                    rx_discard <= 1'b1;
                end else if (!rx_discard || rx_end) begin
                    m_tvalid <= 1'b1;
                    m_tlast  <= rx_end;
                    m_tdata  <= hold_dat;
                end
            end
        end
    end
endmodule

// File: tb/tb_ulpi_link_ctrl.sv
// Directed bench for ulpi_link_ctrl with a simple PHY-side bus driver.
// Latency: n/a (testbench).
// Backpressure: m_tready driven per scenario; Rx beats captured by a monitor queue.
module tb_ulpi_link_ctrl;
    logic       clock = 1'b0;
    logic       reset;
    logic       ulpi_dir;
    logic       ulpi_nxt;
    logic       ulpi_stp;
    wire  [7:0] ulpi_data;
    logic [7:0] phy_dat;
    logic       s_tvalid;
    logic       s_tready;
    logic       s_tlast;
    logic [7:0] s_tdata;
    logic       m_tvalid;
    logic       m_tready;
    logic       m_tlast;
    logic [7:0] m_tdata;
    logic [1:0] linestate;
    logic [1:0] rxevent;
    logic [2:0] err;

    int         checks   = 0;
    int         failures = 0;
    logic [8:0] rxq[$];
    logic [7:0] burst[$];

    always #5 clock = ~clock;

    assign ulpi_data = ulpi_dir ? phy_dat : 8'bz;

    ulpi_link_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .ulpi_dir_i   (ulpi_dir),
        .ulpi_nxt_i   (ulpi_nxt),
        .ulpi_stp_o   (ulpi_stp),
        .ulpi_data_io (ulpi_data),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .s_tlast      (s_tlast),
        .s_tdata      (s_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .m_tdata      (m_tdata),
        .linestate_o  (linestate),
        .rxevent_o    (rxevent),
        .err_o        (err)
    );

    always @(posedge clock) begin
        if (m_tvalid && m_tready) rxq.push_back({m_tlast, m_tdata});
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // PHY burst: turnaround, one RX CMD, then every byte of 'burst', then dir falls.
    task automatic rx_burst(input logic [7:0] cmd);
        ulpi_dir = 1'b1; ulpi_nxt = 1'b0; phy_dat = 8'h00;
        step();
        phy_dat = 8'h5A;
        step();
        phy_dat = cmd;
        step();
        foreach (burst[i]) begin
            ulpi_nxt = 1'b1; phy_dat = burst[i];
            step();
        end
        ulpi_dir = 1'b0; ulpi_nxt = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; ulpi_dir = 1'b0; ulpi_nxt = 1'b1; phy_dat = 8'h00;
        s_tvalid = 1'b1; s_tdata = 8'hD2; s_tlast = 1'b1; m_tready = 1'b1;
        step(); step(); step();
        #2;
        checks++; if (ulpi_stp !== 1'b0) begin failures++; $display("FAIL reset_stp got=%b want=0", ulpi_stp); end
        checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL reset_tready got=%b want=0", s_tready); end
        checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_mtvalid got=%b want=0", m_tvalid); end
        checks++; if (m_tlast !== 1'b0) begin failures++; $display("FAIL reset_mtlast got=%b want=0", m_tlast); end
        checks++; if (linestate !== 2'b00) begin failures++; $display("FAIL reset_linestate got=%b want=00", linestate); end
        checks++; if (rxevent !== 2'b00) begin failures++; $display("FAIL reset_rxevent got=%b want=00", rxevent); end
        checks++; if (err !== 3'b000) begin failures++; $display("FAIL reset_err got=%b want=000", err); end
        reset = 1'b0; s_tvalid = 1'b0; ulpi_nxt = 1'b0;
        step();
        #2;
        checks++; if (ulpi_data !== 8'h00) begin failures++; $display("FAIL idle_bus got=%h want=00", ulpi_data); end
    endtask

    task automatic test_tx_ack();
        s_tvalid = 1'b1; s_tdata = 8'hD2; s_tlast = 1'b1; ulpi_nxt = 1'b0;
        step();
        #2;
        checks++; if (ulpi_data !== 8'h42) begin failures++; $display("FAIL ack_txcmd_bus got=%h want=42", ulpi_data); end
        checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL ack_tready_wait got=%b want=0", s_tready); end
        ulpi_nxt = 1'b1;
        #1;
        checks++; if (s_tready !== 1'b1) begin failures++; $display("FAIL ack_tready got=%b want=1", s_tready); end
        checks++; if (ulpi_stp !== 1'b0) begin failures++; $display("FAIL ack_stp_early got=%b want=0", ulpi_stp); end
        step();
        s_tvalid = 1'b0; ulpi_nxt = 1'b0;
        #2;
        checks++; if (ulpi_stp !== 1'b1) begin failures++; $display("FAIL ack_stp got=%b want=1", ulpi_stp); end
        checks++; if (ulpi_data !== 8'h00) begin failures++; $display("FAIL ack_stop_bus got=%h want=00", ulpi_data); end
        step();
        #2;
        checks++; if (ulpi_stp !== 1'b0) begin failures++; $display("FAIL ack_stp_len got=%b want=0", ulpi_stp); end
    endtask

    task automatic test_tx_data();
        logic [7:0] pkt[4]     = '{8'hC3, 8'h01, 8'h02, 8'h03};
        logic [7:0] exp_bus[6] = '{8'h43, 8'h01, 8'h02, 8'h02, 8'h02, 8'h03};
        logic       nxt_pat[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       exp_rdy[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int idx = 0;
        s_tvalid = 1'b1; s_tdata = pkt[0]; s_tlast = 1'b0; ulpi_nxt = 1'b0;
        step();
        for (int c = 0; c < 6; c++) begin
            ulpi_nxt = nxt_pat[c];
            s_tvalid = (idx < 4);
            s_tdata  = pkt[(idx < 4) ? idx : 3];
            s_tlast  = (idx == 3);
            #2;
            checks++; if (ulpi_data !== exp_bus[c]) begin failures++; $display("FAIL data_bus[%0d] got=%h want=%h", c, ulpi_data, exp_bus[c]); end
            checks++; if (s_tready !== exp_rdy[c]) begin failures++; $display("FAIL data_tready[%0d] got=%b want=%b", c, s_tready, exp_rdy[c]); end
            checks++; if (ulpi_stp !== 1'b0) begin failures++; $display("FAIL data_stp_early[%0d] got=%b want=0", c, ulpi_stp); end
            if (s_tready) idx++;
            step();
        end
        s_tvalid = 1'b0; ulpi_nxt = 1'b0;
        #2;
        checks++; if (idx !== 4) begin failures++; $display("FAIL data_bytes_taken got=%0d want=4", idx); end
        checks++; if (ulpi_stp !== 1'b1) begin failures++; $display("FAIL data_stp got=%b want=1", ulpi_stp); end
        checks++; if (ulpi_data !== 8'h00) begin failures++; $display("FAIL data_stop_bus got=%h want=00", ulpi_data); end
        step();
        #2;
        checks++; if (ulpi_stp !== 1'b0) begin failures++; $display("FAIL data_stp_len got=%b want=0", ulpi_stp); end
    endtask

    task automatic test_rx();
        logic [8:0] exp[3] = '{9'h04B, 9'h0AA, 9'h1BB};
        logic [8:0] got;
        rxq.delete(); m_tready = 1'b1;
        burst = '{8'h4B, 8'hAA, 8'hBB};
        rx_burst(8'h01);
        step(); step();
        checks++; if (rxq.size() != 3) begin failures++; $display("FAIL rx_count got=%0d want=3", rxq.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < rxq.size()) ? rxq[i] : 9'h1FF;
            checks++; if (got !== exp[i]) begin failures++; $display("FAIL rx_beat[%0d] got=%h want=%h", i, got, exp[i]); end
        end
        checks++; if (linestate !== 2'b01) begin failures++; $display("FAIL rx_linestate got=%b want=01", linestate); end
        checks++; if (rxevent !== 2'b00) begin failures++; $display("FAIL rx_rxevent got=%b want=00", rxevent); end
    endtask

    task automatic test_preempt();
        logic [8:0] got;
        rxq.delete(); m_tready = 1'b1;
        s_tvalid = 1'b1; s_tdata = 8'hD2; s_tlast = 1'b1; ulpi_nxt = 1'b0; ulpi_dir = 1'b0;
        step();
        ulpi_dir = 1'b1; ulpi_nxt = 1'b1; phy_dat = 8'h00;
        #2;
        checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL pre_tready got=%b want=0", s_tready); end
        step();
        ulpi_nxt = 1'b0; phy_dat = 8'h77;
        #2;
        checks++; if (ulpi_stp !== 1'b0) begin failures++; $display("FAIL pre_stp_turn got=%b want=0", ulpi_stp); end
        step();
        phy_dat = 8'h12;
        step();
        ulpi_nxt = 1'b1; phy_dat = 8'h5C;
        step();
        ulpi_dir = 1'b0; ulpi_nxt = 1'b0;
        #2;
        checks++; if (ulpi_stp !== 1'b0) begin failures++; $display("FAIL pre_stp_rx got=%b want=0", ulpi_stp); end
        step();
        #2;
        checks++; if (ulpi_data !== 8'h00) begin failures++; $display("FAIL pre_idle_bus got=%h want=00", ulpi_data); end
        step();
        ulpi_nxt = 1'b1;
        #2;
        checks++; if (ulpi_data !== 8'h42) begin failures++; $display("FAIL pre_retry_bus got=%h want=42", ulpi_data); end
        checks++; if (s_tready !== 1'b1) begin failures++; $display("FAIL pre_retry_tready got=%b want=1", s_tready); end
        step();
        s_tvalid = 1'b0; ulpi_nxt = 1'b0;
        #2;
        checks++; if (ulpi_stp !== 1'b1) begin failures++; $display("FAIL pre_retry_stp got=%b want=1", ulpi_stp); end
        step();
        got = (rxq.size() > 0) ? rxq[0] : 9'h1FF;
        checks++; if (rxq.size() != 1) begin failures++; $display("FAIL pre_rx_count got=%0d want=1", rxq.size()); end
        checks++; if (got !== 9'h15C) begin failures++; $display("FAIL pre_rx_beat got=%h want=15c", got); end
        checks++; if (linestate !== 2'b10) begin failures++; $display("FAIL pre_linestate got=%b want=10", linestate); end
        checks++; if (rxevent !== 2'b01) begin failures++; $display("FAIL pre_rxevent got=%b want=01", rxevent); end
    endtask

    task automatic test_underrun();
        s_tvalid = 1'b1; s_tdata = 8'hC3; s_tlast = 1'b0; ulpi_nxt = 1'b1;
        step();
        step();
        s_tdata = 8'h11;
        #2;
        checks++; if (s_tready !== 1'b1) begin failures++; $display("FAIL urun_tready got=%b want=1", s_tready); end
        step();
        s_tvalid = 1'b0;
        #2;
        checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL urun_tready_empty got=%b want=0", s_tready); end
        step();
        ulpi_nxt = 1'b0;
        #2;
        checks++; if (ulpi_stp !== 1'b1) begin failures++; $display("FAIL urun_stp got=%b want=1", ulpi_stp); end
        checks++; if (ulpi_data !== 8'hFF) begin failures++; $display("FAIL urun_abort_bus got=%h want=ff", ulpi_data); end
        checks++; if (err !== 3'b001) begin failures++; $display("FAIL urun_err got=%b want=001", err); end
        step();
        #2;
        checks++; if (ulpi_data !== 8'h00) begin failures++; $display("FAIL urun_idle_bus got=%h want=00", ulpi_data); end
    endtask

    task automatic test_rx_overflow();
        logic [8:0] exp[2] = '{9'h04B, 9'h177};
        logic [8:0] got;
        rxq.delete(); m_tready = 1'b0;
        burst = '{8'hE1, 8'hE2, 8'hE3};
        rx_burst(8'h01);
        #2;
        checks++; if (err !== 3'b011) begin failures++; $display("FAIL ovf_err got=%b want=011", err); end
        checks++; if (m_tvalid !== 1'b1) begin failures++; $display("FAIL ovf_mtvalid got=%b want=1", m_tvalid); end
        checks++; if ({m_tlast, m_tdata} !== 9'h0E1) begin failures++; $display("FAIL ovf_held_beat got=%h want=0e1", {m_tlast, m_tdata}); end
        m_tready = 1'b1;
        step();
        #2;
        checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL ovf_drain got=%b want=0", m_tvalid); end
        checks++; if (rxq.size() != 1) begin failures++; $display("FAIL ovf_count got=%0d want=1", rxq.size()); end
        rxq.delete();
        burst = '{8'h4B, 8'h77};
        rx_burst(8'h01);
        step(); step();
        checks++; if (rxq.size() != 2) begin failures++; $display("FAIL ovf_next_count got=%0d want=2", rxq.size()); end
        for (int i = 0; i < 2; i++) begin
            got = (i < rxq.size()) ? rxq[i] : 9'h1FF;
            checks++; if (got !== exp[i]) begin failures++; $display("FAIL ovf_next_beat[%0d] got=%h want=%h", i, got, exp[i]); end
        end
        checks++; if (err !== 3'b011) begin failures++; $display("FAIL ovf_err_sticky got=%b want=011", err); end
    endtask

    task automatic test_babble();
        int nlast = 0;
        logic [8:0] got;
        rxq.delete(); m_tready = 1'b1;
        ulpi_dir = 1'b1; ulpi_nxt = 1'b0; phy_dat = 8'h00;
        step(); step();
        for (int k = 1; k <= 1029; k++) begin
            ulpi_nxt = 1'b1; phy_dat = k[7:0];
            if (k == 1028) begin
                #2;
                checks++; if (err[2] !== 1'b0) begin failures++; $display("FAIL babble_early got=%b want=0", err[2]); end
            end
            step();
        end
        #2;
        checks++; if (err !== 3'b111) begin failures++; $display("FAIL babble_err got=%b want=111", err); end
        ulpi_dir = 1'b0; ulpi_nxt = 1'b0;
        step(); step(); step();
        foreach (rxq[i]) if (rxq[i][8]) nlast++;
        checks++; if (rxq.size() != 1027) begin failures++; $display("FAIL babble_count got=%0d want=1027", rxq.size()); end
        checks++; if (nlast != 1) begin failures++; $display("FAIL babble_tlasts got=%0d want=1", nlast); end
        got = (rxq.size() > 0) ? rxq[rxq.size() - 1] : 9'h000;
        checks++; if (got !== 9'h103) begin failures++; $display("FAIL babble_last_beat got=%h want=103", got); end
    endtask

    task automatic test_reset_midop();
        logic [8:0] got;
        rxq.delete(); m_tready = 1'b1;
        ulpi_dir = 1'b1; ulpi_nxt = 1'b0; phy_dat = 8'h00;
        step(); step();
        phy_dat = 8'h03;
        step();
        ulpi_nxt = 1'b1; phy_dat = 8'h91;
        step();
        phy_dat = 8'h92;
        step();
        #2;
        checks++; if (linestate !== 2'b11) begin failures++; $display("FAIL mid_linestate got=%b want=11", linestate); end
        reset = 1'b1; phy_dat = 8'h93;
        step();
        #2;
        checks++; if (err !== 3'b000) begin failures++; $display("FAIL mid_err got=%b want=000", err); end
        checks++; if (linestate !== 2'b00) begin failures++; $display("FAIL mid_linestate_clr got=%b want=00", linestate); end
        checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL mid_mtvalid got=%b want=0", m_tvalid); end
        reset = 1'b0; ulpi_dir = 1'b0; ulpi_nxt = 1'b0;
        step(); step(); step();
        got = (rxq.size() > 0) ? rxq[0] : 9'h1FF;
        checks++; if (rxq.size() != 1) begin failures++; $display("FAIL mid_rx_count got=%0d want=1", rxq.size()); end
        checks++; if (got !== 9'h091) begin failures++; $display("FAIL mid_rx_beat got=%h want=091", got); end
    endtask

    initial begin
        test_reset();
        test_tx_ack();
        test_tx_data();
        test_rx();
        test_preempt();
        test_underrun();
        test_rx_overflow();
        test_babble();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
